// File: rtl/fetch_pkg.sv
// Shared types and constants for the LEGv8 instruction-fetch stage.
package fetch_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_STEP = 4;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_FETCH = 2'd1,
    FS_HOLD  = 2'd2,
    FS_DRAIN = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory req/ack bus; the fetch stage is master, memory is slave.
interface fetch_if #(
  parameter int unsigned N = 64
);

  logic                           req;
  logic [N-1:0]                   addr;
  logic                           ack;
  logic [fetch_pkg::INSTR_W-1:0]  rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);

endinterface

// File: rtl/fetch_perf_ctr.sv
// 32-bit saturating event counter, cleared by reset.
module fetch_perf_ctr (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc_i,
  output logic [31:0] count_o
);

  logic [31:0] count_q;

  // Count qualifying cycles, sticking at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= 32'd0;
    end else if (inc_i && (count_q != 32'hFFFF_FFFF)) begin
      count_q <= count_q + 32'd1;
    end else begin
      count_q <= count_q;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, imem req/ack master, one-entry instruction buffer.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module fetch_stage import fetch_pkg::*; #(
  parameter int unsigned  N        = 64,
  parameter logic [N-1:0] RESET_PC = {N{1'b0}}
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall_i,
  input  logic               redirect_i,
  input  logic [N-1:0]       redirect_pc_i,
  fetch_if.master            imem,
  output logic               if_valid_o,
  output logic [N-1:0]       if_pc_o,
  output logic [INSTR_W-1:0] if_instr_o,
  output logic               ifid_en_o,
  output logic [31:0]        fetch_count_o,
  output logic [31:0]        stall_cycles_o
);

  fetch_state_t        state_q, state_d;
  logic [N-1:0]        pc_q, pc_d;
  logic [N-1:0]        addr_q, addr_d;
  logic [N-1:0]        if_pc_q, if_pc_d;
  logic [INSTR_W-1:0]  if_instr_q, if_instr_d;
  logic [N-1:0]        tgt_s;

  assign tgt_s = redirect_pc_i & ~{{(N-2){1'b0}}, 2'b11};

  // Next-state, PC and buffer capture; a redirect overrides the PC in every state.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    case (state_q)
      FS_IDLE: begin
        state_d = FS_FETCH;
      end
      FS_FETCH: begin
        if (redirect_i) begin
          state_d = imem.ack ? FS_FETCH : FS_DRAIN;
        end else if (imem.ack) begin
          state_d    = FS_HOLD;
          if_pc_d    = pc_q;
          if_instr_d = imem.rdata;
        end else begin
          state_d = FS_FETCH;
        end
      end
      FS_HOLD: begin
        if (redirect_i) begin
          state_d = FS_FETCH;
        end else if (!stall_i) begin
          state_d = FS_FETCH;
          pc_d    = pc_q + N'(PC_STEP);
        end else begin
          state_d = FS_HOLD;
        end
      end
      FS_DRAIN: begin
        state_d = imem.ack ? FS_FETCH : FS_DRAIN;
      end
      default: begin
        state_d = FS_IDLE;
      end
    endcase
    if (redirect_i) begin
      pc_d = tgt_s;
    end else begin
      pc_d = pc_d;
    end
    // While draining, the stale request must keep its original address.
    addr_d = (state_d == FS_DRAIN) ? addr_q : pc_d;
  end

  // State, PC, request address and instruction buffer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= FS_IDLE;
      pc_q       <= RESET_PC;
      addr_q     <= RESET_PC;
      if_pc_q    <= {N{1'b0}};
      if_instr_q <= {INSTR_W{1'b0}};
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
    end
  end

  assign imem.req   = (state_q == FS_FETCH) || (state_q == FS_DRAIN);
  assign imem.addr  = addr_q;
  assign if_valid_o = (state_q == FS_HOLD);
  assign if_pc_o    = if_pc_q;
  assign if_instr_o = if_instr_q;
  assign ifid_en_o  = if_valid_o & ~stall_i & ~redirect_i;

`ifdef FETCH_PERF_EN
  fetch_perf_ctr u_fetch_ctr (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (ifid_en_o),
    .count_o (fetch_count_o)
  );

  fetch_perf_ctr u_stall_ctr (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (if_valid_o & stall_i),
    .count_o (stall_cycles_o)
  );
`else
  assign fetch_count_o  = 32'd0;
  assign stall_cycles_o = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized traffic
// compared against a transaction-level reference model.
module tb_fetch_stage;
  import fetch_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        stall0, redir0, stall1, redir1;
  logic [63:0] rpc0, rpc1;
  logic        v0, en0, v1, en1;
  logic [63:0] pc0, pc1;
  logic [31:0] in0, in1, fc0, sc0, fc1, sc1;

  fetch_if #(.N(64)) imem0 ();
  fetch_if #(.N(64)) imem1 ();

  fetch_stage #(.N(64), .RESET_PC(64'h0)) u_dut (
    .clk(clk), .reset(reset), .stall_i(stall0), .redirect_i(redir0), .redirect_pc_i(rpc0),
    .imem(imem0), .if_valid_o(v0), .if_pc_o(pc0), .if_instr_o(in0), .ifid_en_o(en0),
    .fetch_count_o(fc0), .stall_cycles_o(sc0)
  );

  fetch_stage #(.N(64), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) u_wrap (
    .clk(clk), .reset(reset), .stall_i(stall1), .redirect_i(redir1), .redirect_pc_i(rpc1),
    .imem(imem1), .if_valid_o(v1), .if_pc_o(pc1), .if_instr_o(in1), .ifid_en_o(en1),
    .fetch_count_o(fc1), .stall_cycles_o(sc1)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: started / holding an instruction / request outstanding / stale request.
  bit          m_started, m_valid, m_req, m_drop;
  logic [63:0] m_pc, m_addr, m_ipc;
  logic [31:0] m_instr, m_fc, m_sc;

  int          lat_mode;
  int          mem_wait;
  bit          mem_active;
  bit          rand_spur;
  bit          w_ack;
  int          en_seen;
  logic [63:0] fetched[$];
  logic [63:0] held_pc;
  logic [31:0] held_instr;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h5A5A_3C3C;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_started = 1'b0; m_valid = 1'b0; m_req = 1'b0; m_drop = 1'b0;
    m_pc = 64'h0; m_addr = 64'h0; m_ipc = 64'h0; m_instr = 32'h0;
    m_fc = 32'h0; m_sc = 32'h0;
    mem_active = 1'b0; mem_wait = 0;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    stall0 = 1'b0; redir0 = 1'b0; rpc0 = 64'h0; stall1 = 1'b0; redir1 = 1'b0; rpc1 = 64'h0;
    imem0.ack = 1'b0; imem0.rdata = 32'h0; imem1.ack = 1'b0; imem1.rdata = 32'h0;
    model_reset();
    @(posedge clk); #1;
    chk("rst_req", imem0.req, 1'b0);
    chk("rst_addr", imem0.addr, 64'h0);
    chk("rst_valid", v0, 1'b0);
    chk("rst_pc", pc0, 64'h0);
    chk("rst_instr", in0, 32'h0);
    chk("rst_en", en0, 1'b0);
    chk("rst_fcount", fc0, 32'h0);
    chk("rst_scount", sc0, 32'h0);
    chk("rst_wrap_addr", imem1.addr, 64'hFFFF_FFFF_FFFF_FFFC);
    reset = 1'b0;
  endtask

  // One clock: drive inputs, compare against the model, advance the model, step the clock.
  task automatic cycle(input bit st, input bit rd, input logic [63:0] rpc);
    bit          ack;
    bit          en;
    logic [31:0] rd_data;
    logic [63:0] tgt;
    ack = 1'b0;
    if (m_req) begin
      if (!mem_active) begin
        mem_active = 1'b1;
        mem_wait   = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
      end
      ack = (mem_wait == 0);
      if (ack) mem_active = 1'b0;
      else     mem_wait--;
    end else if (rand_spur) begin
      ack = ($urandom_range(0, 3) == 0);
    end
    rd_data = (ack && m_req) ? mem_word(m_addr) : 32'($urandom);
    stall0 = st; redir0 = rd; rpc0 = rpc;
    imem0.ack = ack; imem0.rdata = rd_data;
    imem1.ack = w_ack; imem1.rdata = 32'hCAFE_0000;
    #3;
    en = m_valid && !st && !rd;
    if (imem0.req && ack) fetched.push_back(imem0.addr);
    en_seen += int'(en0);
    chk("req", imem0.req, m_req);
    chk("addr", imem0.addr, m_addr);
    chk("valid", v0, m_valid);
    chk("if_pc", pc0, m_ipc);
    chk("if_instr", in0, m_instr);
    chk("ifid_en", en0, en);
`ifdef FETCH_PERF_EN
    chk("fetch_count", fc0, m_fc);
    chk("stall_cycles", sc0, m_sc);
`else
    chk("fetch_count", fc0, 32'h0);
    chk("stall_cycles", sc0, 32'h0);
`endif
    if (en && m_fc != 32'hFFFF_FFFF) m_fc++;
    if (m_valid && st && m_sc != 32'hFFFF_FFFF) m_sc++;
    tgt = rpc & ~64'h3;
    if (!m_started) begin
      m_started = 1'b1; m_req = 1'b1;
      if (rd) m_pc = tgt;
      m_addr = m_pc;
    end else if (m_valid) begin
      if (rd) begin
        m_valid = 1'b0; m_req = 1'b1; m_pc = tgt; m_addr = tgt;
      end else if (!st) begin
        m_valid = 1'b0; m_req = 1'b1; m_pc = m_pc + 64'd4; m_addr = m_pc;
      end
    end else if (m_drop) begin
      if (rd) m_pc = tgt;
      if (ack) begin m_drop = 1'b0; m_addr = m_pc; end
    end else if (m_req) begin
      if (rd) begin
        m_pc = tgt;
        if (ack) m_addr = tgt;
        else     m_drop = 1'b1;
      end else if (ack) begin
        m_valid = 1'b1; m_req = 1'b0; m_ipc = m_pc; m_instr = rd_data;
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    lat_mode = 0; rand_spur = 1'b0; w_ack = 1'b0; en_seen = 0;
    do_reset();

    // Sequential zero-wait fetch: 0,4,8,C and enable every other cycle.
    fetched.delete(); en_seen = 0;
    repeat (8) cycle(1'b0, 1'b0, 64'h0);
    chk("seq_count", 64'(fetched.size()), 64'd4);
    for (int i = 0; i < 4 && i < fetched.size(); i++) chk("seq_addr", fetched[i], 64'(4 * i));
    chk("seq_en_pulses", 64'(en_seen), 64'd3);

    // Three-cycle memory, then a four-cycle stall while holding.
    lat_mode = 3;
    cycle(1'b0, 1'b0, 64'h0);
    for (int i = 0; i < 20 && !m_valid; i++) cycle(1'b0, 1'b0, 64'h0);
    chk("lat3_valid", v0, 1'b1);
    held_pc = pc0; held_instr = in0;
    repeat (4) cycle(1'b1, 1'b0, 64'h0);
    chk("stall_pc", pc0, 64'h10);
    chk("stall_instr", in0, mem_word(64'h10));
    chk("stall_noreq", imem0.req, 1'b0);
`ifdef FETCH_PERF_EN
    chk("stall_total", sc0, 32'd4);
`else
    chk("stall_total", sc0, 32'd0);
`endif

    // Redirect to an unaligned target while holding.
    cycle(1'b0, 1'b1, 64'h1003);
    chk("redir_hold_valid", v0, 1'b0);
    chk("redir_hold_req", imem0.req, 1'b1);
    chk("redir_hold_addr", imem0.addr, 64'h1000);

    // Redirect while a request to 0x8 is outstanding.
    for (int i = 0; i < 20 && !m_valid; i++) cycle(1'b0, 1'b0, 64'h0);
    cycle(1'b0, 1'b1, 64'h8);
    cycle(1'b0, 1'b1, 64'h2000);
    chk("drain_addr", imem0.addr, 64'h8);
    chk("drain_req", imem0.req, 1'b1);
    for (int i = 0; i < 10 && imem0.addr == 64'h8; i++) cycle(1'b0, 1'b0, 64'h0);
    chk("after_drain_addr", imem0.addr, 64'h2000);
    chk("after_drain_valid", v0, 1'b0);

    // Redirect coincident with ack: no drain cycle.
    lat_mode = 0;
    for (int i = 0; i < 20 && !m_valid; i++) cycle(1'b0, 1'b0, 64'h0);
    chk("pre_coinc_instr", in0, mem_word(64'h2000));
    cycle(1'b0, 1'b0, 64'h0);
    cycle(1'b0, 1'b1, 64'h3000);
    chk("coinc_addr", imem0.addr, 64'h3000);
    chk("coinc_valid", v0, 1'b0);
    cycle(1'b0, 1'b0, 64'h0);
    chk("coinc_hold_pc", pc0, 64'h3000);
    chk("coinc_hold_instr", in0, mem_word(64'h3000));

    // Randomized traffic.
    rand_spur = 1'b1; lat_mode = -1;
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0, {32'($urandom), 32'($urandom)});

    // Reset while a request is outstanding takes effect immediately.
    rand_spur = 1'b0; lat_mode = 3;
    do_reset();
    cycle(1'b0, 1'b0, 64'h0);
    chk("pre_rst_req", imem0.req, 1'b1);
    reset = 1'b1;
    #1;
    chk("midrst_req", imem0.req, 1'b0);
    chk("midrst_valid", v0, 1'b0);
    do_reset();

    // RESET_PC at the top of the address space wraps to 0.
    lat_mode = 0;
    w_ack = 1'b0;
    chk("wrap_idle_req", imem1.req, 1'b0);
    cycle(1'b0, 1'b0, 64'h0);
    chk("wrap_req", imem1.req, 1'b1);
    chk("wrap_addr", imem1.addr, 64'hFFFF_FFFF_FFFF_FFFC);
    w_ack = 1'b1;
    cycle(1'b0, 1'b0, 64'h0);
    w_ack = 1'b0;
    chk("wrap_valid", v1, 1'b1);
    chk("wrap_pc", pc1, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_instr", in1, 32'hCAFE_0000);
    chk("wrap_en", en1, 1'b1);
    chk("wrap_counts", {fc1, sc1}, 64'h0);
    cycle(1'b0, 1'b0, 64'h0);
    chk("wrap_next_addr", imem1.addr, 64'h0);
    chk("wrap_next_req", imem1.req, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
